// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the registered 1xN stream demultiplexer.
package stream_demux_pkg;

  // How the word currently presented at the input will be routed.
  typedef enum logic [1:0] {
    MODE_UNICAST = 2'd0,
    MODE_BCAST   = 2'd1,
    MODE_DROP    = 2'd2
  } mode_e;

  // True when a unicast select addresses an existing channel.
  function automatic logic sel_in_range(input logic [31:0] sel, input logic [31:0] n);
    return (sel < n);
  endfunction

  // Increment a counter of cntw bits, holding at its all-ones value.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int unsigned cntw);
    logic [32:0] max_val;
    max_val = (33'd1 << cntw) - 33'd1;
    if ({1'b0, cnt} >= max_val) begin
      return cnt;
    end
    return cnt + 32'd1;
  endfunction

endpackage

// File: rtl/stream_demux_slot.sv
// One-entry output register for a single demux channel.
module demux_slot
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             free
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Next slot state: a load always wins and leaves the slot full; otherwise
  // a handshake empties it. Data is only touched on load.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  // Slot register; reset drops any held word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  // The slot can take a new word if it is empty or emptying this cycle.
  assign free  = ~valid_q | ready;

endmodule

// File: rtl/stream_demux.sv
// Registered 1xN valid/ready demultiplexer with broadcast and a saturating
// counter of discarded out-of-range words.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  parameter  int CNTW  = 8,
  localparam int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SELW-1:0]    in_sel,
  input  logic               in_bcast,
  output logic [N-1:0]       out_valid,
  input  logic [N-1:0]       out_ready,
  output logic [N*WIDTH-1:0] out_data,
  output logic [CNTW-1:0]    drop_cnt
);

  mode_e           mode;
  logic [N-1:0]    sel_hit;
  logic [N-1:0]    slot_free;
  logic [N-1:0]    slot_load;
  logic            accept;
  logic [CNTW-1:0] drop_cnt_q, drop_cnt_d;

  // Classify the presented word; broadcast overrides the select.
  always_comb begin
    mode = MODE_DROP;
    if (in_bcast) begin
      mode = MODE_BCAST;
    end else if (sel_in_range(32'(in_sel), 32'(N))) begin
      mode = MODE_UNICAST;
    end
  end

  // Ready depends only on routing and slot occupancy, never on in_valid.
  always_comb begin
    in_ready = 1'b1;
    case (mode)
      MODE_BCAST:   in_ready = &slot_free;
      MODE_UNICAST: in_ready = |(sel_hit & slot_free);
      default:      in_ready = 1'b1;
    endcase
  end

  assign accept = in_valid & in_ready;

  // Per-channel select decode, load strobe and slot instance.
  for (genvar gi = 0; gi < N; gi++) begin : g_slot
    assign sel_hit[gi]   = (in_sel == SELW'(gi));
    assign slot_load[gi] = accept & ((mode == MODE_BCAST) |
                                     ((mode == MODE_UNICAST) & sel_hit[gi]));

    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .load     (slot_load[gi]),
      .load_data(in_data),
      .ready    (out_ready[gi]),
      .valid    (out_valid[gi]),
      .data     (out_data[gi*WIDTH +: WIDTH]),
      .free     (slot_free[gi])
    );
  end

  // Count words that were accepted only to be thrown away.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (accept && (mode == MODE_DROP)) begin
      drop_cnt_d = CNTW'(sat_inc(32'(drop_cnt_q), CNTW));
    end
  end

  // Discard counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux: queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_stream_demux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // N=4, WIDTH=8 instance
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic [1:0]  in_sel = '0;
  logic        in_bcast = 1'b0;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready = '0;
  logic [31:0] out_data;
  logic [7:0]  drop_cnt;

  // N=5, CNTW=2 instance for out-of-range selects
  logic        v5 = 1'b0;
  logic        rdy5;
  logic [7:0]  d5 = '0;
  logic [2:0]  sel5 = '0;
  logic        b5 = 1'b0;
  logic [4:0]  ov5;
  logic [4:0]  or5 = '0;
  logic [39:0] od5;
  logic [1:0]  dc5;

  int vectors = 0;
  int miscompares = 0;

  stream_demux #(.WIDTH(8), .N(4), .CNTW(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .drop_cnt(drop_cnt)
  );

  stream_demux #(.WIDTH(8), .N(5), .CNTW(2)) dut5 (
    .clk(clk), .rst(rst), .in_valid(v5), .in_ready(rdy5),
    .in_data(d5), .in_sel(sel5), .in_bcast(b5),
    .out_valid(ov5), .out_ready(or5), .out_data(od5),
    .drop_cnt(dc5)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per channel, the words accepted but not yet consumed.
  logic [7:0] pend [4][$];
  int         drop_m;

  task automatic model_clear();
    for (int k = 0; k < 4; k++) pend[k].delete();
    drop_m = 0;
  endtask

  always @(posedge rst) model_clear();

  // Compare DUT against the model mid-cycle, then advance the model to what
  // the coming rising edge must produce.
  always @(negedge clk) begin
    if (rst) begin
      model_clear();
    end else begin
      logic exp_rdy;
      logic all_free;
      logic [3:0] fr;
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("m_valid%0d", k), 64'(out_valid[k]), 64'(pend[k].size() != 0));
        if (pend[k].size() != 0)
          chk($sformatf("m_data%0d", k), 64'(out_data[k*8 +: 8]), 64'(pend[k][0]));
        fr[k] = (pend[k].size() == 0) || out_ready[k];
      end
      chk("m_drop_cnt", 64'(drop_cnt), 64'(drop_m));
      all_free = (fr == 4'hF);
      if (in_bcast) exp_rdy = all_free;
      else          exp_rdy = fr[in_sel];
      chk("m_in_ready", 64'(in_ready), 64'(exp_rdy));
      for (int k = 0; k < 4; k++)
        if (pend[k].size() != 0 && out_ready[k]) void'(pend[k].pop_front());
      if (in_valid && exp_rdy) begin
        if (in_bcast) for (int k = 0; k < 4; k++) pend[k].push_back(in_data);
        else          pend[in_sel].push_back(in_data);
      end
    end
  end

  // Advance to 2 time units after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] s,
                       input logic b, input logic [3:0] r);
    in_valid = v; in_data = d; in_sel = s; in_bcast = b; out_ready = r;
  endtask

  initial begin
    logic hold;
    logic [1:0] exp_dc [4];
    exp_dc[0] = 2'd1; exp_dc[1] = 2'd2; exp_dc[2] = 2'd3; exp_dc[3] = 2'd3;

    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Reset state and first unicast latency
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'h0);
    chk("rst_out_data", 64'(out_data), 64'h0);
    drive(1, 8'hA5, 2'd2, 0, 4'b1111);
    #1 chk("uni_in_ready", 64'(in_ready), 64'h1);
    chk("uni_not_yet", 64'(out_valid), 64'h0);
    tick();
    chk("uni_out_valid", 64'(out_valid), 64'b0100);
    chk("uni_lane2", 64'(out_data[23:16]), 64'hA5);
    drive(0, 8'h00, 2'd0, 0, 4'b1111);
    tick();
    chk("uni_drained", 64'(out_valid), 64'h0);

    // Back-pressure on channel 1
    drive(1, 8'h11, 2'd1, 0, 4'b1101);
    tick();
    chk("bp_first", 64'(out_data[15:8]), 64'h11);
    drive(1, 8'h22, 2'd1, 0, 4'b1101);
    #1 chk("bp_stall_ready", 64'(in_ready), 64'h0);
    tick();
    chk("bp_held_valid", 64'(out_valid), 64'b0010);
    chk("bp_held_data", 64'(out_data[15:8]), 64'h11);
    out_ready = 4'b1111;
    #1 chk("bp_release_ready", 64'(in_ready), 64'h1);
    tick();
    chk("bp_second_valid", 64'(out_valid), 64'b0010);
    chk("bp_second_data", 64'(out_data[15:8]), 64'h22);
    drive(0, 8'h00, 2'd0, 0, 4'b1111);
    tick();

    // Broadcast blocked by a stalled channel, then accepted in one shot
    drive(1, 8'h77, 2'd2, 0, 4'b1111);
    tick();
    drive(1, 8'h3C, 2'd0, 1, 4'b1011);
    #1 chk("bc_blocked_ready", 64'(in_ready), 64'h0);
    tick();
    chk("bc_no_partial", 64'(out_valid), 64'b0100);
    chk("bc_lane2_kept", 64'(out_data[23:16]), 64'h77);
    out_ready = 4'b1111;
    #1 chk("bc_ready", 64'(in_ready), 64'h1);
    tick();
    chk("bc_all_valid", 64'(out_valid), 64'b1111);
    chk("bc_all_lanes", 64'(out_data), 64'h3C3C3C3C);
    drive(0, 8'h00, 2'd0, 0, 4'b1111);
    tick();

    // Out-of-range selects on the N=5 instance, counter saturates at 3
    or5 = 5'b11111; b5 = 1'b0; sel5 = 3'd6; v5 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d5 = 8'($urandom);
      #1 chk($sformatf("oor_ready%0d", i), 64'(rdy5), 64'h1);
      tick();
      chk($sformatf("oor_drop%0d", i), 64'(dc5), 64'(exp_dc[i]));
      chk($sformatf("oor_valid%0d", i), 64'(ov5), 64'h0);
    end
    sel5 = 3'd4; d5 = 8'h5A;
    tick();
    chk("n5_top_valid", 64'(ov5), 64'b10000);
    chk("n5_top_lane", 64'(od5[39:32]), 64'h5A);
    chk("n5_drop_hold", 64'(dc5), 64'h3);
    v5 = 1'b0;
    tick();

    // Round-robin streaming at full rate
    for (int i = 0; i < 100; i++) begin
      drive(1, 8'($urandom), 2'(i % 4), 0, 4'b1111);
      #1 chk("stream_ready", 64'(in_ready), 64'h1);
      tick();
    end
    drive(0, 8'h00, 2'd0, 0, 4'b1111);
    tick();

    // Random traffic obeying the producer hold rule
    hold = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = 8'($urandom);
        in_sel   = 2'($urandom);
        in_bcast = ($urandom_range(0, 5) == 0);
      end
      out_ready = 4'($urandom);
      #1 hold = in_valid & ~in_ready;
      tick();
    end
    drive(0, 8'h00, 2'd0, 0, 4'b1111);
    tick();

    // Asynchronous reset while slots 0 and 3 are full
    drive(1, 8'hD0, 2'd0, 0, 4'b0110);
    tick();
    drive(1, 8'hD3, 2'd3, 0, 4'b0110);
    tick();
    drive(0, 8'h00, 2'd0, 0, 4'b0110);
    chk("ar_full", 64'(out_valid), 64'b1001);
    #1 rst = 1'b1;
    #1 chk("ar_immediate", 64'(out_valid), 64'h0);
    chk("ar_data_cleared", 64'(out_data), 64'h0);
    @(posedge clk);
    #2 rst = 1'b0;
    out_ready = 4'b1111;
    tick();
    chk("ar_no_stale", 64'(out_valid), 64'h0);
    drive(1, 8'hE1, 2'd3, 0, 4'b1111);
    tick();
    chk("ar_resume", 64'(out_data[31:24]), 64'hE1);
    drive(0, 8'h00, 2'd0, 0, 4'b1111);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stream_demux.md
# stream_demux

Parametrised, registered 1xN demultiplexer for valid/ready streams, generalising the team's combinational 1x4 DEMUX to WIDTH-bit data and N output channels. Each channel has a one-entry output register. Broadcast mode delivers a word to every channel at once. Out-of-range selects are discarded and counted. The block sits between a single producer and N independent consumers.

## Interface
- WIDTH, default 8: data width in bits, ≥1.
- N, default 4: number of output channels, 2..16.
- SELW, default $clog2(N): select width; derived, not overridden.
- CNTW, default 8: width of the discard counter.

- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block accepts the word this cycle.
- in_data  input  WIDTH  payload.
- in_sel  input  SELW  target channel; meaningful when in_bcast=0.
- in_bcast  input  1  deliver to all N channels.
- out_valid  output  N  per-channel valid; bit k belongs to channel k.
- out_ready  input  N  per-channel consumer ready.
- out_data  output  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- drop_cnt  output  CNTW  count of discarded out-of-range words; saturating.

## Operation
- Channel slot k is either empty or full (out_valid[k]). Slot k drains in a cycle when out_valid[k] & out_ready[k].
- Slot k is free when it is empty or draining this cycle.
- Accept means in_valid & in_ready. A word is accepted only on an edge where that is true.
- Unicast (in_bcast=0, in_sel<N):
  - in_ready = free[in_sel].
  - On accept, slot in_sel loads in_data and goes full.
- Broadcast (in_bcast=1):
  - in_ready = AND of free[k] over all k.
  - On accept, every slot loads in_data and goes full. No partial broadcast occurs.
- Out-of-range (in_bcast=0, in_sel≥N, possible only when N is not a power of two):
  - in_ready = 1.
  - On accept, the word is discarded and drop_cnt increments.
  - drop_cnt saturates at 2^CNTW−1.
- in_bcast takes priority over in_sel. in_sel is ignored in broadcast.
- A slot that drains with no new load goes empty. A slot that drains and loads on the same edge stays full with the new data.
- out_data[k] holds its last loaded value while empty. Consumers must ignore it when out_valid[k]=0.
- Channels are independent. A stalled channel k blocks only unicasts to k and all broadcasts.
- Reset values: out_valid=0, every out_data lane=0, drop_cnt=0.
  - in_ready after reset follows the rules above. Slots are empty, so in_ready=1 for any in_valid.
  - Reset mid-transfer discards every held word with no output. Accepts resume on the first edge after rst deasserts.

## Timing
- Latency: 1 cycle. A word accepted on edge t is visible on out_valid/out_data after edge t.
- Throughput: 1 word/cycle sustained on any channel whose consumer holds out_ready=1.
- in_ready is combinational from in_sel, in_bcast and out_ready. No path exists from in_valid to in_ready.
- out_valid, out_data and drop_cnt are registered. No combinational path runs from inputs to these outputs.
- Producer rule: once in_valid=1, in_data, in_sel and in_bcast stay stable until accept. The bench checks this.
- Consumer rule: out_valid[k], once asserted, stays high with stable data until the handshake on channel k.

## Structure
- Package stream_demux_pkg holds:
  - a function that checks whether a select is in range for N;
  - the saturating-increment helper for drop_cnt.
- Sub-module demux_slot: one WIDTH-bit, one-entry register holding valid/data, with ports load, load_data, ready, valid, data.
  - free = ~valid | ready.
  - stream_demux generates N instances.
  - Top-level logic is limited to select decode, in_ready and drop_cnt.

## Test plan
- Reset sweep, N=4, WIDTH=8: after reset, out_valid=4'b0000 and drop_cnt=0. Unicast data 8'hA5 with sel=2 and out_ready=4'b1111 → out_valid=4'b0100 and lane 2=8'hA5 exactly one cycle later.
- Back-pressure, N=4: hold out_ready[1]=0 and send two words to sel=1 → first accepted, in_ready=0 for the second. Raise out_ready[1] → second accepted on the same edge the first drains. Lane 1 shows 8'h11 then 8'h22 with no gap or loss.
- Broadcast, N=4: out_ready=4'b1011 with slot 2 full; broadcast 8'h3C → in_ready=0 and nothing loads. Drain slot 2 → broadcast accepted and out_valid=4'b1111 with all lanes 8'h3C.
- Out-of-range, N=5, SELW=3, CNTW=2: send 4 words with sel=6 → all accepted, out_valid stays 0. drop_cnt goes 1,2,3,3 (saturates).
- Streaming: unicasts to sel=0..3 round-robin for 100 cycles with out_ready all high → one accept per cycle, per-channel output order matches input order, scoreboard clean.
- Async reset mid-operation: assert rst between edges while slots 0 and 3 are full → out_valid=0 immediately without waiting for a clock edge, and no stale word appears after release.
